// File: rtl/systolic_ctrl.sv
// Sequencer for a size x size systolic array: operand buffers, skewed operand feed, result drain.
// Optional abort input is enabled by defining SYSTOLIC_CTRL_ABORT_EN.
module systolic_ctrl #(
  parameter int size = 3,
  parameter int n    = 16,
  parameter int KMAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef SYSTOLIC_CTRL_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] cfg_k,
  input  logic                      ld_valid,
  input  logic                      ld_sel,
  input  logic [$clog2(size)-1:0]   ld_lane,
  input  logic [$clog2(KMAX)-1:0]   ld_k,
  input  logic [n-1:0]              ld_data,
  output logic                      busy,
  output logic                      done,
  output logic                      arr_reset,
  output logic [size-1:0]           r_en,
  output logic [size-1:0]           c_en,
  output logic [size-1:0][n-1:0]    t_w_in,
  output logic [size-1:0][n-1:0]    l_x_in,
  output logic [$clog2(size)-1:0]   s_row,
  output logic [$clog2(size)-1:0]   s_col,
  input  logic [n-1:0]              b_s_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [n-1:0]              res_data,
  output logic                      res_last
);
  localparam int KW  = $clog2(KMAX+1);
  localparam int LW  = $clog2(size);
  localparam int KIW = $clog2(KMAX);
  localparam int TW  = $clog2(KMAX + 2*size - 2);
  localparam int MW  = $clog2(size*size);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, SETTLE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic [MW-1:0]   m_q, m_d;
  logic [n-1:0]    wb_q [size][KMAX];
  logic [n-1:0]    xb_q [size][KMAX];
  logic            feeding, draining, feed_last, drain_last;

  function automatic logic [KW-1:0] sat_k(input logic [KW-1:0] k);
    if (int'(k) > KMAX) return KW'(KMAX);
    return k;
  endfunction

  // Operand buffers are deliberately not reset; they only accept writes while idle.
  always_ff @(posedge clk) begin
    if (ld_valid && state_q == IDLE && int'(ld_k) < KMAX && int'(ld_lane) < size) begin
      if (ld_sel) xb_q[ld_lane][ld_k] <= ld_data;
      else        wb_q[ld_lane][ld_k] <= ld_data;
    end
  end

  assign feeding    = (state_q == FEED);
  assign draining   = (state_q == DRAIN);
  assign feed_last  = (int'(t_q) == int'(k_q) + 2*size - 3);
  assign drain_last = (m_q == MW'(size*size - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    m_d     = m_q;
    case (state_q)
      IDLE:   if (start) begin
                state_d = CLEAR;
                k_d     = sat_k(cfg_k);
              end
      CLEAR:  begin
                t_d     = '0;
                state_d = (k_q == '0) ? SETTLE : FEED;
              end
      FEED:   if (feed_last) begin
                state_d = SETTLE;
                t_d     = '0;
              end else begin
                t_d = t_q + 1'b1;
              end
      SETTLE: begin
                state_d = DRAIN;
                m_d     = '0;
              end
      DRAIN:  if (res_ready) begin
                if (drain_last) begin
                  state_d = DONE;
                  m_d     = '0;
                end else begin
                  m_d = m_q + 1'b1;
                end
              end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SYSTOLIC_CTRL_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      t_d     = '0;
      m_d     = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      m_q     <= m_d;
    end
  end

  // Diagonal skew: lane j sees operand index t-j, zero outside the K-wide window.
  always_comb begin
    for (int j = 0; j < size; j++) begin
      t_w_in[j] = '0;
      l_x_in[j] = '0;
      if (feeding && int'(t_q) >= j && int'(t_q) - j < int'(k_q)) begin
        t_w_in[j] = wb_q[j][KIW'(int'(t_q) - j)];
        l_x_in[j] = xb_q[j][KIW'(int'(t_q) - j)];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign arr_reset = (state_q == CLEAR);
  assign r_en      = {size{feeding}};
  assign c_en      = {size{feeding}};
  assign res_valid = draining;
  assign res_last  = draining && drain_last;
  assign res_data  = b_s_in;
  assign s_row     = draining ? LW'(int'(m_q) / size) : '0;
  assign s_col     = draining ? LW'(int'(m_q) % size) : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural 3x3 PE array answers readback, jobs come from a vector table.
// Abort coverage is compiled in when SYSTOLIC_CTRL_ABORT_EN is defined.
module tb_systolic_ctrl;
  localparam int SZ = 3;
  localparam int N  = 16;
  localparam int KM = 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] cfg_k = '0;
  logic ld_valid = 1'b0, ld_sel = 1'b0;
  logic [1:0] ld_lane = '0, ld_k = '0;
  logic [N-1:0] ld_data = '0;
  logic busy, done, arr_reset, res_valid, res_last;
  logic res_ready = 1'b1;
  logic [SZ-1:0] r_en, c_en;
  logic [SZ-1:0][N-1:0] t_w_in, l_x_in;
  logic [1:0] s_row, s_col;
  logic [N-1:0] b_s_in, res_data;
`ifdef SYSTOLIC_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.size(SZ), .n(N), .KMAX(KM)) dut (
    .clk(clk), .reset(reset),
`ifdef SYSTOLIC_CTRL_ABORT_EN
    .abort(abort),
`endif
    .start(start), .cfg_k(cfg_k),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_lane(ld_lane), .ld_k(ld_k), .ld_data(ld_data),
    .busy(busy), .done(done), .arr_reset(arr_reset), .r_en(r_en), .c_en(c_en),
    .t_w_in(t_w_in), .l_x_in(l_x_in), .s_row(s_row), .s_col(s_col), .b_s_in(b_s_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  // Output-stationary PE array: x flows right, w flows down, each PE accumulates x*w.
  logic [N-1:0] xin [3][3], win [3][3], xr [3][3], wr [3][3], acc [3][3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      xin[i][0] = l_x_in[i];
      win[0][i] = t_w_in[i];
      for (int j = 1; j < 3; j++) begin
        xin[i][j] = xr[i][j-1];
        win[j][i] = wr[j-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (arr_reset) begin
          acc[i][j] <= '0; xr[i][j] <= '0; wr[i][j] <= '0;
        end else if (r_en[i] && c_en[j]) begin
          acc[i][j] <= acc[i][j] + xin[i][j] * win[i][j];
          xr[i][j]  <= xin[i][j];
          wr[i][j]  <= win[i][j];
        end
  end

  assign b_s_in = (s_row < 2'd3 && s_col < 2'd3) ? acc[s_row][s_col] : '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endfunction

  function automatic logic [8:0][15:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [8:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2);
    r[3] = 16'(a3); r[4] = 16'(a4); r[5] = 16'(a5);
    r[6] = 16'(a6); r[7] = 16'(a7); r[8] = 16'(a8);
    return r;
  endfunction

  // W[j][k] = wa*(j+1) + wb*(k+1) + wc ; X[i][k] = xa*(i+1) + xb*(k+1) + xc
  task automatic load(input int wa, wb, wc, xa, xb, xc);
    for (int sel = 0; sel < 2; sel++)
      for (int lane = 0; lane < 3; lane++)
        for (int kk = 0; kk < KM; kk++) begin
          @(negedge clk);
          ld_valid = 1'b1;
          ld_sel   = 1'(sel);
          ld_lane  = 2'(lane);
          ld_k     = 2'(kk);
          ld_data  = (sel == 1) ? 16'(xa*(lane+1) + xb*(kk+1) + xc)
                                : 16'(wa*(lane+1) + wb*(kk+1) + wc);
        end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic run_job(input int id, input int kcfg, input int feed_exp, input int rmode,
                         input logic [8:0][15:0] expv, input bit misc);
    int feed_n = 0, clr_n = 0, hs = 0, dn = 0, last_cyc = -1, done_cyc = -1, rpos = 0;
    bit finished = 0, zero_ok = 1, en_ok = 1, stalled = 0;
    bit busy_first = 0, busy_done = 0, idle_after = 0;
    logic [19:0] saved = '0;
    @(negedge clk); start = 1'b1; cfg_k = 3'(kcfg);
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      res_ready = (rmode == 0) ? 1'b1 : (rpos % 3 == 0);
      ld_valid  = misc && r_en[0];
      ld_sel = 1'b1; ld_lane = 2'd2; ld_k = 2'd3; ld_data = 16'd99;
      start     = misc && res_valid;
      #1;
      if (arr_reset) clr_n++;
      if (r_en != '0 || c_en != '0) begin
        feed_n++;
        if (r_en != 3'b111 || c_en != 3'b111) en_ok = 0;
      end else if (t_w_in != '0 || l_x_in != '0) zero_ok = 0;
      if (cyc == 0) busy_first = busy;
      if (res_valid) begin
        if (stalled) chk($sformatf("v%0d_stall_hold", id), {res_data, s_row, s_col}, saved);
        if (res_ready) begin
          if (hs < 9) begin
            chk($sformatf("v%0d_res%0d", id, hs), res_data, expv[hs]);
            chk($sformatf("v%0d_pos%0d", id, hs), {s_row, s_col, res_last},
                {2'(hs / 3), 2'(hs % 3), (hs == 8)});
          end
          hs++; last_cyc = cyc; stalled = 0;
        end else begin
          stalled = 1; saved = {res_data, s_row, s_col};
        end
        rpos++;
      end
      if (done) begin
        dn++; done_cyc = cyc; busy_done = busy;
      end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        idle_after = !busy; finished = 1;
      end
      @(negedge clk);
    end
    start = 1'b0; ld_valid = 1'b0; res_ready = 1'b1;
    chk($sformatf("v%0d_finished", id), finished, 1);
    chk($sformatf("v%0d_feed_cycles", id), feed_n, feed_exp);
    chk($sformatf("v%0d_clear_cycles", id), clr_n, 1);
    chk($sformatf("v%0d_handshakes", id), hs, 9);
    chk($sformatf("v%0d_done_pulses", id), dn, 1);
    chk($sformatf("v%0d_done_latency", id), done_cyc - last_cyc, 1);
    chk($sformatf("v%0d_busy_flags", id), {busy_first, busy_done, idle_after}, 3'b111);
    chk($sformatf("v%0d_feed_gating", id), {zero_ok, en_ok}, 2'b11);
  endtask

  typedef struct {
    int kcfg; int feed; int rmode;
    int wa; int wb; int wc; int xa; int xb; int xc;
    logic [8:0][15:0] expv;
  } vec_t;
  vec_t vt[6];

  initial begin
    int fn;
    vt[0] = '{1, 5, 0, 1, 0, 0, 1, 0, 0, mk9(1, 2, 3, 2, 4, 6, 3, 6, 9)};
    vt[1] = '{4, 8, 0, 0, 0, 2, 0, 0, 2, mk9(16, 16, 16, 16, 16, 16, 16, 16, 16)};
    vt[2] = '{2, 6, 1, 1, 0, 0, 1, 0, 0, mk9(2, 4, 6, 4, 8, 12, 6, 12, 18)};
    vt[3] = '{0, 0, 0, 0, 0, 5, 0, 0, 7, mk9(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[4] = '{3, 7, 0, 0, 1, 0, 1, 0, 0, mk9(6, 6, 6, 12, 12, 12, 18, 18, 18)};
    vt[5] = '{7, 8, 1, 0, 0, 1, 0, 1, 0, mk9(10, 10, 10, 10, 10, 10, 10, 10, 10)};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", {busy, done, arr_reset, r_en, c_en, res_valid, res_last, s_row, s_col}, '0);
    chk("reset_data", {t_w_in, l_x_in}, '0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("idle_after_reset", {busy, done, res_valid}, '0);

    for (int v = 0; v < 6; v++) begin
      load(vt[v].wa, vt[v].wb, vt[v].wc, vt[v].xa, vt[v].xb, vt[v].xc);
      run_job(v, vt[v].kcfg, vt[v].feed, vt[v].rmode, vt[v].expv, 1'b0);
    end

    // Reset in the middle of FEED, then rerun on the untouched buffers.
    load(0, 0, 2, 0, 0, 2);
    @(negedge clk); start = 1'b1; cfg_k = 3'd4;
    @(negedge clk); start = 1'b0;
    fn = 0;
    for (int c = 0; c < 40 && fn < 4; c++) begin
      #1;
      if (r_en[0]) fn++;
      if (fn < 4) @(negedge clk);
    end
    chk("reset_feed_reached_t3", fn, 4);
    #2 reset = 1'b0;
    #1;
    chk("midjob_reset_ctl", {busy, done, arr_reset, r_en, c_en, res_valid, res_last, s_row, s_col}, '0);
    chk("midjob_reset_data", {t_w_in, l_x_in}, '0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("midjob_reset_idle", {busy, done}, '0);
    run_job(10, 4, 8, 0, mk9(16, 16, 16, 16, 16, 16, 16, 16, 16), 1'b1);

`ifdef SYSTOLIC_CTRL_ABORT_EN
    begin
      int seen_m4 = 0, dn = 0;
      load(1, 0, 0, 1, 0, 0);
      @(negedge clk); start = 1'b1; cfg_k = 3'd1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 60 && seen_m4 == 0; c++) begin
        #1;
        if (res_valid && s_row == 2'd1 && s_col == 2'd1) seen_m4 = 1;
        else @(negedge clk);
      end
      chk("abort_reached_m4", seen_m4, 1);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #1;
      chk("abort_idle", {busy, res_valid, r_en, done}, '0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk); #1;
        if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
